acc_arbiter: RTL and testbench

Round-robin controller that shares one `accumulator_8bit` between `N_REQ` requesters. Each granted requester runs a job: the accumulator is cleared, `len` data beats are streamed in over a valid/ready handshake, and one result pulse is returned tagged with the requester id. The block sits between the requester-side sample sources and the single accumulator datapath, which it instantiates and sequences.

---
 rtl/acc_pkg.sv | 13 +
 rtl/accumulator_8bit.sv | 16 +
 rtl/acc_arbiter.sv | 140 ++++++++++++++
 tb/tb_acc_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared state encoding and default widths for the accumulator arbiter.
package acc_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int ID_W_DEF  = 2;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/accumulator_8bit.sv
// 8-bit wrap-around accumulator with synchronous clear and load-to-add.
module accumulator_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic [7:0] acc_out
);
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out <= 8'd0;
        end else if (load) begin
            acc_out <= acc_out + data_in;
        end
    end
endmodule

// File: rtl/acc_arbiter.sv
// Round-robin sharing of one accumulator between requesters, one job per grant.
//   state | meaning
//   IDLE  | waiting for a request; round-robin pick on any req bit
//   CLEAR | accumulator, beat counter and overflow flag cleared
//   ACCUM | granted requester streams len beats over valid/ready
//   DONE  | one-cycle result pulse tagged with the owner id
module acc_arbiter
    import acc_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]       gnt,
    input  logic [N_REQ-1:0]       in_valid,
    input  logic [N_REQ*8-1:0]     in_data,
    output logic [N_REQ-1:0]       in_ready,
    output logic                   res_valid,
    output logic [7:0]             res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_ovf,
    output logic                   busy
);
    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   pick_id;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic              ovf;
    logic              beat;
    logic              acc_rst;
    logic [7:0]        beat_data;
    logic [7:0]        acc_out;
    logic [8:0]        sum9;

    // Lowest offset from last+1 wins, so scan offsets high to low and keep the final hit.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [ID_W-1:0]  prev);
        logic [ID_W-1:0] sel;
        int              idx;
        sel = prev;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(prev) + k) % N_REQ;
            if (r[idx]) sel = ID_W'(idx);
        end
        return sel;
    endfunction

    assign pick_id   = rr_pick(req, last);
    assign beat_data = in_data[int'(id)*8 +: 8];
    assign sum9      = {1'b0, acc_out} + {1'b0, beat_data};
    assign acc_rst   = rst | (state == S_CLEAR);
    assign res_data  = acc_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        gnt        = '0;
        in_ready   = '0;
        res_valid  = 1'b0;
        res_id     = '0;
        res_ovf    = 1'b0;
        beat       = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (|req) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                gnt        = N_REQ'(1) << id;
                state_next = (len != '0) ? S_ACCUM : S_DONE;
            end
            S_ACCUM: begin
                gnt      = N_REQ'(1) << id;
                in_ready = N_REQ'(1) << id;
                beat     = in_valid[id];
                if (beat && (cnt == len - LEN_W'(1))) state_next = S_DONE;
            end
            S_DONE: begin
                res_valid  = 1'b1;
                res_id     = id;
                res_ovf    = ovf;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id   <= '0;
            len  <= '0;
            last <= ID_W'(N_REQ - 1);
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        id   <= pick_id;
                        len  <= req_len[int'(pick_id)*LEN_W +: LEN_W];
                        last <= pick_id;
                    end
                end
                S_CLEAR: begin
                    cnt <= '0;
                    ovf <= 1'b0;
                end
                S_ACCUM: begin
                    if (beat) begin
                        cnt <= cnt + LEN_W'(1);
                        if (sum9[8]) ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    accumulator_8bit u_acc (
        .clk     (clk),
        .rst     (acc_rst),
        .load    (beat),
        .data_in (beat_data),
        .acc_out (acc_out)
    );
endmodule

// File: tb/tb_acc_arbiter.sv
// Directed bench for acc_arbiter: results go through a scoreboard queue checked by a monitor.
module tb_acc_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  gnt;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ovf;
    logic        busy;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         passed = 0;
    logic [7:0] dv[16];

    acc_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int rid, input logic [7:0] d, input logic o);
        exp_t e;
        e.id   = 2'(rid);
        e.data = d;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    // Monitor: every result pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got id=%0d data=%0d, required no pulse", res_id, res_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_id",   32'(res_id),   32'(e.id));
                chk("res_ovf",  32'(res_ovf),  32'(e.ovf));
            end
        end
    end

    // Called in IDLE; other requesters drive noise on in_valid/in_data throughout.
    task automatic run_job(input int rid, input int rlen, input logic [7:0] ed,
                           input logic eo, input logic [31:0] vpat);
        int beats;
        int cyc;
        push_exp(rid, ed, eo);
        req                   = '0;
        req[rid]              = 1'b1;
        req_len[rid*4 +: 4]   = 4'(rlen);
        in_valid              = ~(4'b0001 << rid);
        in_data               = {4{8'h55}};
        tick();
        chk("gnt_clear",   32'(gnt),      32'(1) << rid);
        chk("ready_clear", 32'(in_ready), 32'd0);
        req = '0;
        tick();
        beats = 0;
        cyc   = 0;
        while (beats < rlen && cyc < 32) begin
            chk("gnt_accum",   32'(gnt),      32'(1) << rid);
            chk("ready_accum", 32'(in_ready), 32'(1) << rid);
            in_valid[rid]         = vpat[cyc];
            in_data[rid*8 +: 8]   = dv[beats];
            tick();
            if (vpat[cyc]) beats++;
            cyc++;
        end
        chk("res_valid_done", 32'(res_valid), 32'd1);
        chk("gnt_done",       32'(gnt),       32'd0);
        in_valid = '0;
        tick();
        chk("res_valid_pulse", 32'(res_valid), 32'd0);
        chk("busy_idle",       32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_len  = '0;
        in_valid = '0;
        in_data  = '0;
        tick();
        tick();
        chk("rst_gnt",       32'(gnt),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_res_ovf",   32'(res_ovf),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        tick();

        // Round robin: all requesting, len 1, data 1 -> grants 0,1,2,3,0.
        req      = 4'hF;
        req_len  = 16'h1111;
        in_valid = 4'hF;
        in_data  = {4{8'd1}};
        for (int j = 0; j < 5; j++) begin
            push_exp(j % 4, 8'd1, 1'b0);
            tick();
            chk("rr_gnt", 32'(gnt), 32'(1) << (j % 4));
            tick();
            chk("rr_ready", 32'(in_ready), 32'(1) << (j % 4));
            tick();
            chk("rr_done", 32'(res_valid), 32'd1);
            if (j == 4) req = '0;
            tick();
        end
        in_valid = '0;
        req_len  = '0;

        // Single job: 10+20+30.
        dv[0] = 8'd10; dv[1] = 8'd20; dv[2] = 8'd30;
        run_job(0, 3, 8'd60, 1'b0, 32'hFFFF_FFFF);

        // Overflow: 200+100 wraps to 44.
        dv[0] = 8'd200; dv[1] = 8'd100;
        run_job(2, 2, 8'd44, 1'b1, 32'hFFFF_FFFF);

        // Backpressure: valid pattern 1,0,0,1,1 carries 5,6,7.
        dv[0] = 8'd5; dv[1] = 8'd6; dv[2] = 8'd7;
        run_job(1, 3, 8'd18, 1'b0, 32'b11001);

        // Zero-length job.
        run_job(1, 0, 8'd0, 1'b0, 32'hFFFF_FFFF);

        // Reset after 2 of 4 beats.
        req                 = 4'b0010;
        req_len             = '0;
        req_len[1*4 +: 4]   = 4'd4;
        tick();
        req = '0;
        tick();
        in_valid[1]         = 1'b1;
        in_data[1*8 +: 8]   = 8'd50;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_gnt",       32'(gnt),       32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_res_data",  32'(res_data),  32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        rst      = 1'b0;
        in_valid = '0;
        tick();
        dv[0] = 8'd7; dv[1] = 8'd8;
        run_job(3, 2, 8'd15, 1'b0, 32'hFFFF_FFFF);

        tick();
        tick();
        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
